cpu_bus_xfer: RTL and testbench

Parametrised multi-beat bus transfer engine that moves 1..WORD_BYTES bytes between the CPU core and the external bus using the o_bus_clk / i_bus_data_ready handshake. It replaces the hand-coded single-beat load/store and edst0/edst1 push sequencing inside cpu. The core issues one request (address, size, direction, write data). The block serialises it into byte beats, ascending for normal loads/stores and descending for stack pushes, then returns assembled read data with a done pulse.

---
 rtl/cpu_bus_xfer.sv | 165 ++++++++++++++++
 tb/tb_cpu_bus_xfer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_xfer.sv
// Multi-beat byte-serial bus transfer engine: splits one CPU request into ascending or descending
// byte beats on the o_bus_clk / i_bus_data_ready handshake. Optional watchdog: BUS_TIMEOUT_EN.
module cpu_bus_xfer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BEAT_W      = 8,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned SIZE_W      = $clog2(WORD_BYTES),
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req,
  input  logic                         i_we,
  input  logic                         i_dir,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic [SIZE_W-1:0]            i_size,
  input  logic [BEAT_W*WORD_BYTES-1:0] i_wdata,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [BEAT_W*WORD_BYTES-1:0] o_rdata,
  output logic                         o_bus_clk,
  output logic                         o_bus_we,
  output logic [ADDR_W-1:0]            o_bus_addr,
  output logic [BEAT_W-1:0]            o_bus_data,
  input  logic                         i_bus_data_ready,
  input  logic [BEAT_W-1:0]            i_bus_data
);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease} state_e;

  state_e                              state_q;
  logic [SIZE_W-1:0]                   beat_q;
  logic [SIZE_W-1:0]                   size_q;
  logic                                we_q;
  logic                                dir_q;
  logic [ADDR_W-1:0]                   addr_q;
  logic [WORD_BYTES-1:0][BEAT_W-1:0]   wdata_q;
  logic [WORD_BYTES-1:0][BEAT_W-1:0]   rdata_q;
  logic [WORD_BYTES-1:0][BEAT_W-1:0]   wdata_in;

  logic [SIZE_W-1:0]                   cur_lane;
  logic [SIZE_W-1:0]                   nxt_beat;
  logic [SIZE_W-1:0]                   nxt_lane;
  logic [ADDR_W-1:0]                   nxt_addr;
  logic [BEAT_W-1:0]                   nxt_data;

  assign wdata_in = i_wdata;
  assign o_rdata  = rdata_q;
  // Descending pushes fill lanes from the top so memory still ends up little-endian.
  assign cur_lane = dir_q ? size_q - beat_q : beat_q;

  // Address/data of the beat about to be launched: beat 0 from the live request when idle,
  // otherwise the following beat of the latched request.
  always_comb begin
    nxt_beat = beat_q + SIZE_W'(1);
    nxt_lane = dir_q ? size_q - nxt_beat : nxt_beat;
    nxt_addr = dir_q ? addr_q - ADDR_W'(nxt_beat) : addr_q + ADDR_W'(nxt_beat);
    nxt_data = wdata_q[nxt_lane];
    if (state_q == StIdle) begin
      nxt_beat = '0;
      nxt_lane = i_dir ? i_size : '0;
      nxt_addr = i_addr;
      nxt_data = wdata_in[nxt_lane];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q;
  logic            err_q;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bus_clk  <= 1'b0;
      o_bus_we   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_data <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            size_q     <= i_size;
            we_q       <= i_we;
            dir_q      <= i_dir;
            addr_q     <= i_addr;
            wdata_q    <= wdata_in;
            rdata_q    <= '0;
            beat_q     <= '0;
            o_busy     <= 1'b1;
            o_bus_clk  <= 1'b1;
            o_bus_we   <= i_we;
            o_bus_addr <= nxt_addr;
            o_bus_data <= nxt_data;
            state_q    <= StAssert;
`ifdef BUS_TIMEOUT_EN
            tmo_q      <= '0;
`endif
          end
        end
        StAssert: begin
          if (i_bus_data_ready) begin
            if (!we_q) rdata_q[cur_lane] <= i_bus_data;
            o_bus_clk <= 1'b0;
            state_q   <= StRelease;
`ifdef BUS_TIMEOUT_EN
            tmo_q     <= '0;
          end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            // Abandon the transfer; lanes not yet received stay zero.
            o_bus_clk <= 1'b0;
            o_bus_we  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            err_q     <= 1'b1;
            beat_q    <= '0;
            tmo_q     <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_q     <= tmo_q + TmoW'(1);
`endif
          end
        end
        StRelease: begin
          if (beat_q != size_q) begin
            beat_q     <= nxt_beat;
            o_bus_clk  <= 1'b1;
            o_bus_addr <= nxt_addr;
            o_bus_data <= nxt_data;
            state_q    <= StAssert;
          end else begin
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_bus_we <= 1'b0;
            beat_q   <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_xfer.sv
// Self-checking bench for cpu_bus_xfer: directed vector table, async-reset and timeout sequences,
// and random transfers checked against a little-endian byte-memory model.
module tb_cpu_bus_xfer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req, i_we, i_dir;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic [31:0] i_wdata;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rdata;
  logic        o_bus_clk, o_bus_we;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_data;
  logic        i_bus_data_ready;
  logic [7:0]  i_bus_data;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  cpu_bus_xfer #(
    .ADDR_W      (32),
    .BEAT_W      (8),
    .WORD_BYTES  (4),
    .TIMEOUT_CYC (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_req            (i_req),
    .i_we             (i_we),
    .i_dir            (i_dir),
    .i_addr           (i_addr),
    .i_size           (i_size),
    .i_wdata          (i_wdata),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err),
    .o_rdata          (o_rdata),
    .o_bus_clk        (o_bus_clk),
    .o_bus_we         (o_bus_we),
    .o_bus_addr       (o_bus_addr),
    .o_bus_data       (o_bus_data),
    .i_bus_data_ready (i_bus_data_ready),
    .i_bus_data       (i_bus_data)
  );

  typedef struct {
    logic        we;
    logic        dir;
    logic [31:0] addr;
    int          size;
    logic [31:0] wdata;
    logic [15:0] waits;      // extra ready-wait cycles per beat, one nibble per beat
    logic [31:0] pre;        // memory image preloaded at the low address, little-endian
    logic [31:0] exp_rdata;
    int          exp_cyc;    // clock edges from accept edge to the o_done cycle
    bit          poke;       // fire a stray i_req while busy
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] lane_mask(input int n);
    logic [63:0] m;
    m = (64'h1 << (8 * n)) - 64'h1;
    return m[31:0];
  endfunction

  task automatic run_xfer(input string nm, input logic we, input logic dir, input logic [31:0] addr,
                          input int size, input logic [31:0] wdata, input logic [15:0] waits,
                          input logic [31:0] pre, input logic [31:0] exp_rdata,
                          input int exp_cyc, input bit poke);
    int          n;
    int          cyc;
    int          wleft;
    int          beat;
    bit          prev_clk, we_ok, stable_ok, ord_ok;
    logic [31:0] hold, lo, img;
    logic [31:0] baddr[$];
    n  = size + 1;
    lo = dir ? addr - 32'(n - 1) : addr;
    for (int j = 0; j < n; j++) mem[lo + 32'(j)] = pre[8*j +: 8];
    @(negedge clk);
    i_req = 1'b1; i_we = we; i_dir = dir; i_addr = addr; i_size = 2'(size); i_wdata = wdata;
    @(negedge clk);
    // Scramble request inputs: the engine must work from its latched copy.
    i_req = 1'b0; i_we = ~we; i_dir = ~dir; i_addr = $urandom; i_wdata = $urandom;
    i_size = 2'($urandom);
    cyc = 0; beat = -1; wleft = 0; prev_clk = 1'b0; we_ok = 1'b1; stable_ok = 1'b1;
    hold = '0;
    while (cyc < 300 && !o_done) begin
      if (o_bus_clk) begin
        if (!prev_clk) begin
          beat++;
          baddr.push_back(o_bus_addr);
          hold  = o_bus_addr;
          wleft = (beat < 4) ? int'(waits[4*beat +: 4]) : 0;
        end else if (o_bus_addr !== hold) begin
          stable_ok = 1'b0;
        end
        if (o_bus_we !== we) we_ok = 1'b0;
        if (wleft > 0) begin
          i_bus_data_ready = 1'b0;
          i_bus_data       = 8'($urandom);
          wleft--;
        end else begin
          i_bus_data_ready = 1'b1;
          i_bus_data       = rd(o_bus_addr);
          if (we) mem[o_bus_addr] = o_bus_data;
        end
      end else begin
        // Ready outside ASSERT must be ignored.
        i_bus_data_ready = 1'($urandom);
        i_bus_data       = 8'($urandom);
      end
      if (poke && cyc == 1) begin
        i_req = 1'b1; i_addr = 32'h0000_9999;
      end else begin
        i_req = 1'b0;
      end
      prev_clk = o_bus_clk;
      @(negedge clk);
      cyc++;
    end
    i_req = 1'b0; i_bus_data_ready = 1'b0;
    chk({nm, "_latency"}, cyc, exp_cyc);
    chk({nm, "_done_ctl"}, {o_done, o_err, o_busy, o_bus_clk, o_bus_we}, 5'b10000);
    chk({nm, "_rdata"}, o_rdata, exp_rdata);
    chk({nm, "_beats"}, beat + 1, n);
    ord_ok = (baddr.size() == n);
    for (int k = 0; k < baddr.size() && k < n; k++)
      if (baddr[k] !== (dir ? addr - 32'(k) : addr + 32'(k))) ord_ok = 1'b0;
    chk({nm, "_order"}, ord_ok, 1'b1);
    chk({nm, "_we_stable"}, {we_ok, stable_ok}, 2'b11);
    if (we) begin
      img = '0;
      for (int j = 0; j < n; j++) img[8*j +: 8] = rd(lo + 32'(j));
      chk({nm, "_wimage"}, img, wdata & lane_mask(n));
    end
    @(negedge clk);
    chk({nm, "_pulse"}, {o_done, o_busy}, 2'b00);
  endtask

  initial begin
    int          rises, cnt, hi, n, size, ecyc;
    bit          prev, seen;
    logic        we, dir;
    logic [31:0] addr, wdata, pre;
    logic [15:0] waits;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 0, 32'h0,         16'h0000, 32'h0000_00A5,
                32'h0000_00A5, 2, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h00FF_FFFE, 3, 32'h1122_3344, 16'h0000, 32'h0,
                32'h0, 8, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_01FF, 1, 32'h0000_BEEF, 16'h0000, 32'h0,
                32'h0, 4, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_2000, 1, 32'h0,         16'h0030, 32'h0000_1234,
                32'h0000_1234, 7, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 3, 32'h0,         16'h0000, 32'hCAFE_F00D,
                32'hCAFE_F00D, 8, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1, 32'h0,         16'h0000, 32'h0000_7788,
                32'h0000_7788, 4, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0100, 2, 32'h0,         16'h0201, 32'h00AA_BBCC,
                32'h00AA_BBCC, 9, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0001, 3, 32'hDEAD_BEEF, 16'h0000, 32'h0,
                32'h0, 8, 1'b0};

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_dir = 1'b0; i_addr = '0; i_size = '0;
    i_wdata = '0; i_bus_data_ready = 1'b0; i_bus_data = '0;
    #1;
    chk("reset_ctl", {o_busy, o_done, o_err, o_bus_clk, o_bus_we}, 5'b0);
    chk("reset_data", {o_rdata, o_bus_addr, o_bus_data}, 72'h0);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run_xfer($sformatf("vec%0d", v), vecs[v].we, vecs[v].dir, vecs[v].addr, vecs[v].size,
               vecs[v].wdata, vecs[v].waits, vecs[v].pre, vecs[v].exp_rdata, vecs[v].exp_cyc,
               vecs[v].poke);

    // Async reset in the ASSERT phase of beat 2 of a 4-beat write.
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_dir = 1'b0; i_addr = 32'h0000_3000; i_size = 2'd3;
    i_wdata = 32'h5566_7788;
    @(negedge clk);
    i_req = 1'b0; rises = 0; prev = 1'b0; cnt = 0;
    while (rises < 3 && cnt < 40) begin
      if (o_bus_clk && !prev) rises++;
      if (rises < 3) begin
        prev = o_bus_clk;
        i_bus_data_ready = o_bus_clk;
        @(negedge clk);
        cnt++;
      end
    end
    chk("rst_reach_beat2", rises, 3);
    i_bus_data_ready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rst_async_ctl", {o_busy, o_done, o_err, o_bus_clk, o_bus_we}, 5'b0);
    chk("rst_async_data", {o_rdata, o_bus_addr, o_bus_data}, 72'h0);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("rst_no_done", seen, 1'b0);
    run_xfer("rst_restart", 1'b1, 1'b0, 32'h0000_3000, 3, 32'hA1B2_C3D4, 16'h0, 32'h0, 32'h0, 8,
             1'b0);

`ifdef BUS_TIMEOUT_EN
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b0; i_dir = 1'b0; i_addr = 32'h0000_0040; i_size = 2'd0;
    @(negedge clk);
    i_req = 1'b0; i_bus_data_ready = 1'b0; hi = 0; cnt = 0;
    while (!o_done && cnt < 50) begin
      if (o_bus_clk) hi++;
      cnt++;
      @(negedge clk);
    end
    chk("tmo_assert_cycles", hi, 4);
    chk("tmo_done_err", {o_done, o_err, o_busy, o_bus_clk}, 4'b1100);
    chk("tmo_rdata", o_rdata, 32'h0);
    @(negedge clk);
    chk("tmo_pulse", {o_done, o_err, o_busy}, 3'b000);
`endif

    // Random transfers; expectations come from the byte-memory image and 2N+waits latency.
    for (int t = 0; t < 40; t++) begin
      we    = 1'($urandom);
      dir   = 1'($urandom);
      size  = int'($urandom_range(0, 3));
      addr  = (t % 3 == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 3)) : $urandom;
      wdata = $urandom;
      pre   = $urandom;
      waits = 16'($urandom) & 16'h3333;
      n     = size + 1;
      ecyc  = 2 * n;
      for (int k = 0; k < n; k++) ecyc += int'(waits[4*k +: 4]);
      run_xfer($sformatf("rnd%0d", t), we, dir, addr, size, wdata, waits, pre,
               we ? 32'h0 : (pre & lane_mask(n)), ecyc, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
